// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for instr_encoder_loader.
// The master drives symbolic instruction fields; the slave (the encoder) returns ready and drives imem writes.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 6
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS fields (R-type, LW, SW, BEQ, J, ADDI) into 32-bit words and writes them to sequential imem.
// Optional NOP padding of the unwritten tail on finish is enabled by defining INSTR_ENC_NOP_PAD_EN.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     finish,
    instr_encoder_loader_if.slave    bus,
    output logic [ADDR_W:0]          count,
    output logic                     busy,
    output logic                     done,
    output logic                     err_illegal
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR1_L  = ADDR_W'(1);

    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_LW    = 3'd1;
    localparam logic [2:0] KIND_SW    = 3'd2;
    localparam logic [2:0] KIND_BEQ   = 3'd3;
    localparam logic [2:0] KIND_J     = 3'd4;
    localparam logic [2:0] KIND_ADDI  = 3'd5;

`ifdef INSTR_ENC_NOP_PAD_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_PAD = 2'd2, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DONE = 2'd3} state_t;
`endif

    state_t            state_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              ready_s;
    logic              legal_s;
    logic              xfer_s;
    logic              wr_s;
    logic [ADDR_W:0]   cnt_next_s;
    logic [31:0]       enc_s;

    // Shamt is always zero; illegal kinds encode to zero but are never written.
    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        case (kind)
            KIND_RTYPE: w = {6'b000000, rs, rt, rd, 5'b00000, funct};
            KIND_LW:    w = {6'b100011, rs, rt, imm};
            KIND_SW:    w = {6'b101011, rs, rt, imm};
            KIND_BEQ:   w = {6'b000100, rs, rt, imm};
            KIND_J:     w = {6'b000010, target};
            KIND_ADDI:  w = {6'b001000, rs, rt, imm};
            default:    w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Handshake decode: ready depends only on state and words already accepted.
    always_comb begin
        ready_s = (state_r == ST_LOAD) && (count_r < DEPTH_L);
        legal_s = (bus.in_kind <= KIND_ADDI);
        xfer_s  = bus.in_valid && ready_s;
        wr_s    = xfer_s && legal_s;
        if (wr_s) begin
            cnt_next_s = count_r + ONE_L;
        end else begin
            cnt_next_s = count_r;
        end
        enc_s = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                       bus.in_funct, bus.in_imm, bus.in_target);
    end

    // Session FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            wr_ptr_r     <= BASE_L;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= BASE_L;
            imem_wdata_r <= 32'h0000_0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_LOAD;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        count_r     <= '0;
                        err_r       <= 1'b0;
                        wr_ptr_r    <= BASE_L;
                        imem_addr_r <= BASE_L;
                    end
                end
                ST_LOAD: begin
                    if (wr_s) begin
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= wr_ptr_r;
                        imem_wdata_r <= enc_s;
                        wr_ptr_r     <= wr_ptr_r + PTR1_L;
                        count_r      <= cnt_next_s;
                    end
                    if (xfer_s && !legal_s) begin
                        err_r <= 1'b1;
                    end
                    // The word accepted in this cycle is written in the next, whatever state follows.
                    if (wr_s && (cnt_next_s == DEPTH_L)) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (finish) begin
`ifdef INSTR_ENC_NOP_PAD_EN
                        if (cnt_next_s < DEPTH_L) begin
                            state_r <= ST_PAD;
                        end else begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
`else
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`endif
                    end
                end
`ifdef INSTR_ENC_NOP_PAD_EN
                ST_PAD: begin
                    if (count_r < DEPTH_L) begin
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= wr_ptr_r;
                        imem_wdata_r <= 32'h0000_0000;
                        wr_ptr_r     <= wr_ptr_r + PTR1_L;
                        count_r      <= count_r + ONE_L;
                    end
                    if ((count_r + ONE_L) >= DEPTH_L) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = ready_s;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign count          = count_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err_illegal    = err_r;

endmodule
